// File: rtl/layer_serializer_pkg.sv
// rtl/layer_serializer_pkg.sv - layer-level constants and FSM encoding shared by the NN layer blocks
package layer_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Counter width for an n-entry index; a one-word layer still needs a 1-bit counter.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/layer_serializer.sv
// rtl/layer_serializer.sv - captures a parallel layer output frame and emits it one word per cycle
module layer_serializer
  import layer_serializer_pkg::*;
#(
  parameter int NN        = 30,
  parameter int dataWidth = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NN-1:0]           i_valid,
  input  logic [NN*dataWidth-1:0] i_data,
  input  logic                    err_clr,
  output logic [dataWidth-1:0]    x_out,
  output logic                    x_valid,
  output logic                    busy,
  output logic                    err_overrun,
  output logic                    err_mismatch
);

  localparam int             IW   = idx_width(NN);
  localparam logic [IW-1:0]  LAST = IW'(NN - 1);

  state_e                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  ovr_q, ovr_d;
  logic                  mis_q, mis_d;
  logic                  capture;
  logic                  ovr_set;
  logic                  mis_set;
  logic [dataWidth-1:0]  buf_q [NN];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    capture = 1'b0;
    ovr_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_valid[0]) begin
          capture = 1'b1;
          idx_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (idx_q == LAST) begin
          // A strobe on the last word chains the next frame with no bubble.
          idx_d = '0;
          if (i_valid[0]) begin
            capture = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          idx_d   = idx_q + 1'b1;
          ovr_set = i_valid[0];
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
    mis_set = capture && (i_valid != '1);
    // A new error wins over a simultaneous clear.
    ovr_d   = (ovr_q & ~err_clr) | ovr_set;
    mis_d   = (mis_q & ~err_clr) | mis_set;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ovr_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ovr_q   <= ovr_d;
      mis_q   <= mis_d;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      for (int k = 0; k < NN; k++) begin
        buf_q[k] <= i_data[k*dataWidth +: dataWidth];
      end
    end
  end

  assign busy         = (state_q == SHIFT);
  assign x_valid      = busy;
  assign x_out        = busy ? buf_q[idx_q] : '0;
  assign err_overrun  = ovr_q;
  assign err_mismatch = mis_q;

endmodule

// File: tb/tb_layer_serializer.sv
// tb/tb_layer_serializer.sv - scoreboard bench for layer_serializer at NN=4 and NN=1
module tb_layer_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  i_valid = '0;
  logic [63:0] i_data = '0;
  logic        err_clr = 1'b0;
  logic [15:0] x_out;
  logic        x_valid, busy, err_overrun, err_mismatch;

  logic [0:0]  i_valid1 = '0;
  logic [15:0] i_data1 = '0;
  logic [15:0] x_out1;
  logic        x_valid1, busy1, err_overrun1, err_mismatch1;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q [$];
  logic [15:0] exp1_q [$];

  always #5 clk = ~clk;

  layer_serializer #(.NN(4), .dataWidth(16)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .err_clr(err_clr),
    .x_out(x_out), .x_valid(x_valid), .busy(busy),
    .err_overrun(err_overrun), .err_mismatch(err_mismatch)
  );

  layer_serializer #(.NN(1), .dataWidth(16)) dut1 (
    .clk(clk), .rst(rst), .i_valid(i_valid1), .i_data(i_data1), .err_clr(err_clr),
    .x_out(x_out1), .x_valid(x_valid1), .busy(busy1),
    .err_overrun(err_overrun1), .err_mismatch(err_mismatch1)
  );

  // Every emitted word of the NN=4 instance is matched against the scoreboard.
  always @(negedge clk) begin
    if (x_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL stream_unexpected: got word %h, required no word", x_out);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (x_out !== e) begin
          n_err++;
          $display("FAIL stream_word: got %h, required %h", x_out, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] v, input logic [63:0] d, input bit push);
    i_valid = v;
    i_data  = d;
    if (push) begin
      for (int k = 0; k < 4; k++) exp_q.push_back(d[k*16 +: 16]);
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_cmp++; if (x_valid !== 1'b0)     begin n_err++; $display("FAIL reset_x_valid: got %b, required 0", x_valid); end
    n_cmp++; if (x_out !== 16'h0)      begin n_err++; $display("FAIL reset_x_out: got %h, required 0000", x_out); end
    n_cmp++; if (busy !== 1'b0)        begin n_err++; $display("FAIL reset_busy: got %b, required 0", busy); end
    n_cmp++; if (err_overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b, required 0", err_overrun); end
    n_cmp++; if (err_mismatch !== 1'b0) begin n_err++; $display("FAIL reset_mismatch: got %b, required 0", err_mismatch); end
    // Strobe present in the same cycle reset is released: honoured on the first edge.
    send(4'hF, 64'h0404_0303_0202_0101, 1'b1);
    rst = 1'b1;
    tick();
    i_valid = '0;
    n_cmp++; if (x_valid !== 1'b1) begin n_err++; $display("FAIL first_edge_strobe: got x_valid %b, required 1", x_valid); end
    repeat (4) tick();
  endtask

  task automatic test_single();
    send(4'hF, 64'h0044_0033_0022_0011, 1'b1);
    tick();
    i_valid = '0;
    for (int c = 1; c <= 4; c++) begin
      n_cmp++; if (x_valid !== 1'b1) begin n_err++; $display("FAIL single_valid_n%0d: got %b, required 1", c, x_valid); end
      tick();
    end
    n_cmp++; if (x_valid !== 1'b0) begin n_err++; $display("FAIL single_end_valid: got %b, required 0", x_valid); end
    n_cmp++; if (x_out !== 16'h0)  begin n_err++; $display("FAIL single_end_x_out: got %h, required 0000", x_out); end
    n_cmp++; if ({err_overrun, err_mismatch} !== 2'b00) begin n_err++; $display("FAIL single_errors: got %b, required 00", {err_overrun, err_mismatch}); end
  endtask

  task automatic test_back_to_back();
    send(4'hF, 64'h0014_0013_0012_0011, 1'b1);
    tick();
    i_valid = '0;
    repeat (3) tick();
    send(4'hF, 64'h00A3_00A2_00A1_00A0, 1'b1);
    tick();
    i_valid = '0;
    n_cmp++; if (x_out !== 16'h00A0 || x_valid !== 1'b1) begin n_err++; $display("FAIL b2b_first_word: got %b/%h, required 1/00a0", x_valid, x_out); end
    for (int c = 6; c <= 8; c++) begin
      tick();
      n_cmp++; if (x_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid_n%0d: got %b, required 1", c, x_valid); end
    end
    tick();
    n_cmp++; if (x_valid !== 1'b0) begin n_err++; $display("FAIL b2b_end_valid: got %b, required 0", x_valid); end
    n_cmp++; if ({err_overrun, err_mismatch} !== 2'b00) begin n_err++; $display("FAIL b2b_errors: got %b, required 00", {err_overrun, err_mismatch}); end
  endtask

  task automatic test_overrun();
    send(4'hF, 64'h0054_0053_0052_0051, 1'b1);
    tick();
    i_valid = '0;
    tick();
    send(4'hF, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);
    tick();
    i_valid = '0;
    n_cmp++; if (err_overrun !== 1'b1) begin n_err++; $display("FAIL overrun_set: got %b, required 1", err_overrun); end
    repeat (3) tick();
    n_cmp++; if (err_overrun !== 1'b1 || x_valid !== 1'b0) begin n_err++; $display("FAIL overrun_sticky: got ovr %b valid %b, required 1/0", err_overrun, x_valid); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_cmp++; if (err_overrun !== 1'b0) begin n_err++; $display("FAIL overrun_clear: got %b, required 0", err_overrun); end
    // Clear colliding with a new overrun leaves the flag set.
    send(4'hF, 64'h0064_0063_0062_0061, 1'b1);
    tick();
    i_valid = '0;
    tick();
    send(4'hF, 64'h1111_2222_3333_4444, 1'b0);
    err_clr = 1'b1;
    tick();
    i_valid = '0;
    err_clr = 1'b0;
    n_cmp++; if (err_overrun !== 1'b1) begin n_err++; $display("FAIL overrun_clr_collide: got %b, required 1", err_overrun); end
    repeat (3) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic test_mismatch();
    send(4'b0101, 64'h0074_0073_0072_0071, 1'b1);
    tick();
    i_valid = '0;
    n_cmp++; if (err_mismatch !== 1'b1) begin n_err++; $display("FAIL mismatch_set: got %b, required 1", err_mismatch); end
    n_cmp++; if (err_overrun !== 1'b0)  begin n_err++; $display("FAIL mismatch_no_overrun: got %b, required 0", err_overrun); end
    repeat (4) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_cmp++; if (err_mismatch !== 1'b0) begin n_err++; $display("FAIL mismatch_clear: got %b, required 0", err_mismatch); end
  endtask

  task automatic test_reset_mid_frame();
    send(4'hF, 64'h0084_0083_0082_0081, 1'b1);
    tick();
    i_valid = '0;
    tick();
    #2;
    rst = 1'b0;
    #1;
    n_cmp++; if (x_valid !== 1'b0 || x_out !== 16'h0 || busy !== 1'b0) begin n_err++; $display("FAIL midreset_outputs: got %b/%h/%b, required 0/0000/0", x_valid, x_out, busy); end
    n_cmp++; if (exp_q.size() !== 3) begin n_err++; $display("FAIL midreset_words_left: got %0d, required 3", exp_q.size()); end
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b1;
    repeat (3) tick();
    n_cmp++; if (x_valid !== 1'b0) begin n_err++; $display("FAIL midreset_idle: got %b, required 0", x_valid); end
    send(4'hF, 64'h0094_0093_0092_0091, 1'b1);
    tick();
    i_valid = '0;
    repeat (4) tick();
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL midreset_restart: got %0d words left, required 0", exp_q.size()); end
  endtask

  task automatic test_nn1();
    logic [15:0] e;
    for (int c = 0; c < 8; c++) begin
      i_valid1 = 1'b1;
      i_data1  = 16'($urandom);
      exp1_q.push_back(i_data1);
      tick();
      e = exp1_q.pop_front();
      n_cmp++; if (x_valid1 !== 1'b1 || x_out1 !== e) begin n_err++; $display("FAIL nn1_word_%0d: got %b/%h, required 1/%h", c, x_valid1, x_out1, e); end
    end
    i_valid1 = 1'b0;
    tick();
    n_cmp++; if (x_valid1 !== 1'b0 || err_overrun1 !== 1'b0 || err_mismatch1 !== 1'b0) begin n_err++; $display("FAIL nn1_end: got valid %b ovr %b mis %b, required 0/0/0", x_valid1, err_overrun1, err_mismatch1); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_mismatch();
    test_reset_mid_frame();
    test_nn1();
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL scoreboard_drain: got %0d words left, required 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
